mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 36 +++
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit. The pipeline and hazard
// logic import the same operation codes and latencies.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Visible latency of each operation class, in busy cycles.
    localparam logic [3:0] MULT_CYC = 4'd5;
    localparam logic [3:0] DIV_CYC  = 4'd10;

    // True for the four codes that occupy the unit for several cycles.
    function automatic logic is_md_launch(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the two multiply codes.
    function automatic logic is_md_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | unit free; start launches an op, MTHI/MTLO write directly
//   ST_RUN   | result held in pending regs, cnt counts down to commit
//
// The arithmetic is done combinationally in the launch cycle; only the
// architectural update of HI/LO is delayed so the pipeline sees the same
// latency as a multi-cycle iterative unit.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pending_hi_q, pending_hi_d;
    logic [31:0] pending_lo_q, pending_lo_d;
    logic        pending_wr_q, pending_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        launch;
    logic        mul_sext;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] div_num;
    logic [31:0] div_den;
    logic [31:0] div_den_safe;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign launch = start && is_md_launch(md_op);

    // Product and quotient/remainder of the current operands. One unsigned
    // multiplier and one unsigned divider serve both signed and unsigned ops;
    // signed division runs on magnitudes and fixes the signs afterwards, which
    // also makes 0x80000000 / -1 wrap back to 0x80000000 cleanly.
    always_comb begin
        mul_sext     = (md_op == MD_MULT);
        mul_a        = {{32{mul_sext & src_a[31]}}, src_a};
        mul_b        = {{32{mul_sext & src_b[31]}}, src_b};
        product      = mul_a * mul_b;

        div_signed   = (md_op == MD_DIV);
        a_neg        = div_signed & src_a[31];
        b_neg        = div_signed & src_b[31];
        div_num      = a_neg ? (~src_a + 32'd1) : src_a;
        div_den      = b_neg ? (~src_b + 32'd1) : src_b;
        div_by_zero  = (src_b == 32'd0);
        div_den_safe = div_by_zero ? 32'd1 : div_den;
        uquot        = div_num / div_den_safe;
        urem         = div_num % div_den_safe;
        quot         = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
        rem          = a_neg ? (~urem + 32'd1) : urem;

        if (is_md_mult(md_op)) begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    // State register and all datapath flops; reset clears pending work too.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            pending_hi_q <= 32'd0;
            pending_lo_q <= 32'd0;
            pending_wr_q <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            pending_wr_q <= pending_wr_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    // Next-state: leave IDLE on a launch, return on the last busy cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch)          state_d = ST_RUN;
            ST_RUN:  if (cnt_q == 4'd1)   state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Outputs: busy tracks RUN directly so it drops in the commit cycle.
    always_comb begin
        busy = (state_q == ST_RUN);
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath updates: capture result at launch, count down, commit at the
    // end. A divide by zero occupies the unit but never writes HI/LO.
    always_comb begin
        cnt_d        = cnt_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        pending_wr_d = pending_wr_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    cnt_d        = is_md_mult(md_op) ? MULT_CYC : DIV_CYC;
                    pending_hi_d = res_hi;
                    pending_lo_d = res_lo;
                    pending_wr_d = is_md_mult(md_op) || !div_by_zero;
                end else if (md_op == MD_MTHI) begin
                    hi_d = src_a;
                end else if (md_op == MD_MTLO) begin
                    lo_d = src_a;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1 && pending_wr_q) begin
                    hi_d = pending_hi_q;
                    lo_d = pending_lo_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: each launch pushes the expected HI/LO
// and busy length; a negedge monitor pops and compares when busy falls.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;
    logic prev_busy = 1'b0;
    int   busy_len = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: count busy cycles, compare on each busy falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                busy_len++;
            end else if (prev_busy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check32("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check32("busy_len", 32'(busy_len), 32'(e.len));
                    check32("hi", hi, e.hi);
                    check32("lo", lo, e.lo);
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) check32("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int len);
        exp_t e;
        e.hi = eh; e.lo = el; e.len = len;
        sb_q.push_back(e);
        md_op = op; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0; md_op = MD_NONE;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        tick();

        launch(MD_MULT,  32'hFFFFFFFF, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        launch(MD_MULTU, 32'hFFFFFFFF, 32'd2,       32'h00000001, 32'hFFFFFFFE, 5);
        launch(MD_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        launch(MD_DIVU,  32'd7,        32'd2,       32'd1,        32'd3,        10);
        launch(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,       32'hFFFFFFFD, 10);
        launch(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,       32'h80000000, 10);

        // MTHI without start, then divide by zero leaves HI/LO alone.
        md_op = MD_MTHI; src_a = 32'h12345678;
        tick();
        md_op = MD_NONE;
        check32("mthi_hi", hi, 32'h12345678);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        launch(MD_DIVU, 32'd5, 32'd0, 32'h12345678, 32'h80000000, 10);

        // MTLO with start set must not set busy.
        md_op = MD_MTLO; src_a = 32'hAABBCCDD; start = 1'b1;
        tick();
        start = 1'b0; md_op = MD_NONE;
        check32("mtlo_lo", lo, 32'hAABBCCDD);
        check32("mtlo_hi_kept", hi, 32'h12345678);
        check32("mtlo_busy", {31'd0, busy}, 32'd0);

        // MULT with a second start on busy cycle 2 and MTLO on busy cycle 3.
        begin
            exp_t e;
            e.hi = 32'd0; e.lo = 32'd12; e.len = 5;
            sb_q.push_back(e);
            md_op = MD_MULT; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
            tick();
            start = 1'b0; md_op = MD_NONE;
            tick();
            md_op = MD_DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
            tick();
            start = 1'b0; md_op = MD_MTLO; src_a = 32'hDEADBEEF;
            tick();
            md_op = MD_NONE;
            wait_idle();
            tick();
            check32("ignored_busy", {31'd0, busy}, 32'd0);
        end

        launch(MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);

        // Reset on the third busy cycle aborts the MULT with no later write.
        begin
            exp_t e;
            e.hi = 32'd0; e.lo = 32'd0; e.len = 3;
            sb_q.push_back(e);
            md_op = MD_MULT; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
            tick();
            start = 1'b0; md_op = MD_NONE;
            tick();
            tick();
            reset = 1'b0;
            tick();
            reset = 1'b1;
            repeat (8) tick();
            check32("abort_hi", hi, 32'd0);
            check32("abort_lo", lo, 32'd0);
            check32("abort_busy", {31'd0, busy}, 32'd0);
        end

        // Reset wins over a simultaneous start and over MTHI.
        md_op = MD_MULTU; src_a = 32'd9; src_b = 32'd9; start = 1'b1; reset = 1'b0;
        tick();
        start = 1'b0;
        check32("rst_vs_start_busy", {31'd0, busy}, 32'd0);
        md_op = MD_MTHI; src_a = 32'hCAFEF00D;
        tick();
        reset = 1'b1; md_op = MD_NONE;
        check32("rst_vs_mthi_hi", hi, 32'd0);
        tick();
        tick();

        check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
